// File: rtl/pwm_pkg.sv
// Shared PWM types and prescaler sizing helpers.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned out_hz);
    return clk_hz / out_hz;
  endfunction

  // A divide-by-one prescaler still needs a 1-bit counter to stay legal.
  function automatic int unsigned div_cnt_bits(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: counts 0..DIV-1 and flags tick while sitting at DIV-1.
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic i_fclk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CntW = div_cnt_bits(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign o_tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = o_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_fclk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multi_pwm.sv
// Multi-channel PWM with edge/center counting and shadowed duty/mode committed at period
// boundaries.
module multi_pwm
  import pwm_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY  = 100_000_000,
  parameter int unsigned OUTPUT_FREQUENCY = 20_000,
  parameter int unsigned CHANNELS         = 4,
  parameter int unsigned WIDTH_BITS       = 8
) (
  input  logic                           i_fclk,
  input  logic                           i_reset,
  input  logic [CHANNELS*WIDTH_BITS-1:0] i_width,
  input  logic                           i_center,
  input  logic                           i_load,
  input  logic [CHANNELS-1:0]            i_enable,
  output logic [CHANNELS-1:0]            o_pwm_out,
  output logic                           o_period_start,
  output logic                           o_pending
);

  localparam int unsigned Div = calc_div(CLOCK_FREQUENCY, OUTPUT_FREQUENCY);
  localparam logic [WIDTH_BITS-1:0] MaxVal = '1;
  localparam logic [WIDTH_BITS-1:0] OneVal = WIDTH_BITS'(1);

  logic                           tick, boundary;
  logic [WIDTH_BITS-1:0]          phase_q, phase_d;
  logic                           dir_down_q, dir_down_d;
  pwm_mode_e                      mode_q, mode_d;
  pwm_mode_e                      sh_mode_q, sh_mode_d;
  logic [CHANNELS*WIDTH_BITS-1:0] duty_q, duty_d;
  logic [CHANNELS*WIDTH_BITS-1:0] sh_width_q, sh_width_d;
  logic                           pending_q, pending_d;
  logic [CHANNELS-1:0]            pwm_q, pwm_d;
  logic                           ps_q, ps_d;

  pwm_tick_gen #(
    .DIV (Div)
  ) u_tick_gen (
    .i_fclk  (i_fclk),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  always_comb begin
    if (mode_q == PWM_EDGE) boundary = tick && (phase_q == MaxVal);
    else                    boundary = tick && dir_down_q && (phase_q == OneVal);
  end

  always_comb begin
    phase_d    = phase_q;
    dir_down_d = dir_down_q;
    mode_d     = mode_q;
    duty_d     = duty_q;
    sh_width_d = sh_width_q;
    sh_mode_d  = sh_mode_q;
    pending_d  = pending_q;
    ps_d       = boundary;

    if (tick) begin
      if (boundary) begin
        phase_d    = '0;
        dir_down_d = 1'b0;
      end else if (mode_q == PWM_EDGE) begin
        phase_d = phase_q + 1'b1;
      end else if (!dir_down_q) begin
        if (phase_q == MaxVal) begin
          phase_d    = MaxVal - 1'b1;
          dir_down_d = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end else begin
        phase_d = phase_q - 1'b1;
      end
    end

    if (i_load) begin
      sh_width_d = i_width;
      sh_mode_d  = pwm_mode_e'(i_center);
    end

    // A load landing on the boundary bypasses the shadow and commits straight away.
    if (boundary && i_load) begin
      duty_d    = i_width;
      mode_d    = pwm_mode_e'(i_center);
      pending_d = 1'b0;
    end else if (boundary && pending_q) begin
      duty_d    = sh_width_q;
      mode_d    = sh_mode_q;
      pending_d = 1'b0;
    end else if (i_load) begin
      pending_d = 1'b1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_cmp
    assign pwm_d[k] = i_enable[k] && (duty_q[k*WIDTH_BITS +: WIDTH_BITS] > phase_q);
  end

  always_ff @(posedge i_fclk) begin
    if (i_reset) begin
      phase_q    <= '0;
      dir_down_q <= 1'b0;
      mode_q     <= PWM_EDGE;
      duty_q     <= '0;
      sh_width_q <= '0;
      sh_mode_q  <= PWM_EDGE;
      pending_q  <= 1'b0;
      pwm_q      <= '0;
      ps_q       <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      dir_down_q <= dir_down_d;
      mode_q     <= mode_d;
      duty_q     <= duty_d;
      sh_width_q <= sh_width_d;
      sh_mode_q  <= sh_mode_d;
      pending_q  <= pending_d;
      pwm_q      <= pwm_d;
      ps_q       <= ps_d;
    end
  end

  assign o_pwm_out      = pwm_q;
  assign o_period_start = ps_q;
  assign o_pending      = pending_q;

endmodule

// File: tb/tb_multi_pwm.sv
// Scoreboard bench for multi_pwm: a tick-index reference model predicts every cycle.
module tb_multi_pwm;

  localparam int unsigned Clk = 8;
  localparam int unsigned Out = 2;
  localparam int Div = 4;
  localparam int Ch  = 2;
  localparam int Wb  = 4;
  localparam int Max = (1 << Wb) - 1;

  typedef struct packed {
    logic [Ch-1:0] pwm;
    logic          ps;
    logic          pend;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [Ch*Wb-1:0]  width = '0;
  logic              center = 1'b0;
  logic              load = 1'b0;
  logic [Ch-1:0]     en = '0;
  logic [Ch-1:0]     pwm_out;
  logic              period_start;
  logic              pending;

  multi_pwm #(
    .CLOCK_FREQUENCY  (Clk),
    .OUTPUT_FREQUENCY (Out),
    .CHANNELS         (Ch),
    .WIDTH_BITS       (Wb)
  ) dut (
    .i_fclk         (clk),
    .i_reset        (rst),
    .i_width        (width),
    .i_center       (center),
    .i_load         (load),
    .i_enable       (en),
    .o_pwm_out      (pwm_out),
    .o_period_start (period_start),
    .o_pending      (pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: position within the period as a tick index.
  int         m_pre = 0;
  int         m_t = 0;
  bit         m_c = 0;
  logic [Wb-1:0] m_duty [Ch];
  logic [Ch*Wb-1:0] m_sh = '0;
  bit         m_sh_c = 0;
  bit         m_pend = 0;
  exp_t       sb_q[$];

  int cyc = 0;
  int last_ps = -1;
  int ps_gap = 0;
  bit pend_seen = 0;

  function automatic int period_of(input bit c);
    return c ? 2 * Max : Max + 1;
  endfunction

  function automatic int phase_of(input int t, input bit c);
    if (!c) return t;
    return (t <= Max) ? t : 2 * Max - t;
  endfunction

  function automatic bit model_bnd_next();
    return (m_pre == Div - 1) && (m_t == period_of(m_c) - 1);
  endfunction

  task automatic step();
    exp_t e, g;
    bit tick, bnd;
    e = '0;
    if (rst) begin
      m_pre = 0; m_t = 0; m_c = 0; m_sh = '0; m_sh_c = 0; m_pend = 0;
      for (int k = 0; k < Ch; k++) m_duty[k] = '0;
    end else begin
      tick = (m_pre == Div - 1);
      bnd  = model_bnd_next();
      for (int k = 0; k < Ch; k++)
        e.pwm[k] = en[k] && (int'(m_duty[k]) > phase_of(m_t, m_c));
      e.ps = bnd;
      m_pre = tick ? 0 : m_pre + 1;
      if (tick) m_t = bnd ? 0 : m_t + 1;
      if (bnd && load) begin
        for (int k = 0; k < Ch; k++) m_duty[k] = width[k*Wb +: Wb];
        m_c = center; m_pend = 0;
      end else if (bnd && m_pend) begin
        for (int k = 0; k < Ch; k++) m_duty[k] = m_sh[k*Wb +: Wb];
        m_c = m_sh_c; m_pend = 0;
      end else if (load) begin
        m_pend = 1;
      end
      if (load) begin m_sh = width; m_sh_c = center; end
      e.pend = m_pend;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    g = sb_q.pop_front();
    check_eq("sb_pwm", 32'(pwm_out), 32'(g.pwm));
    check_eq("sb_period_start", 32'(period_start), 32'(g.ps));
    check_eq("sb_pending", 32'(pending), 32'(g.pend));
    if (period_start) begin
      if (last_ps >= 0) ps_gap = cyc - last_ps;
      last_ps = cyc;
    end
    if (pending) pend_seen = 1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load_once(input logic [Ch*Wb-1:0] w, input logic c);
    width = w; center = c; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_ps(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < budget);
    check_eq("ps_seen", 32'(period_start), 32'd1);
  endtask

  task automatic wait_model_bnd(input int budget);
    int n = 0;
    while (!model_bnd_next() && n < budget) begin
      step();
      n++;
    end
    check_eq("bnd_found", 32'(model_bnd_next()), 32'd1);
  endtask

  task automatic run_window(input int n, output int hi0, output int hi1, output int nps);
    hi0 = 0; hi1 = 0; nps = 0;
    for (int i = 0; i < n; i++) begin
      step();
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
      nps += int'(period_start);
    end
  endtask

  initial begin
    int n, hi0, hi1, nps, center_hi;

    center_hi = 0;
    for (int t = 0; t < 2 * Max; t++)
      if (phase_of(t, 1'b1) < 5) center_hi += Div;

    // Reset state
    steps(3);
    check_eq("rst_pwm", 32'(pwm_out), 32'd0);
    check_eq("rst_ps", 32'(period_start), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);

    // Edge mode, ch0=4, ch1=0
    rst = 1'b0;
    en = 2'b11;
    load_once(8'h04, 1'b0);
    wait_ps(200, n);
    step();
    run_window(64, hi0, hi1, nps);
    check_eq("edge4_hi0", 32'(hi0), 32'd16);
    check_eq("edge4_hi1", 32'(hi1), 32'd0);
    check_eq("edge4_nps", 32'(nps), 32'd1);
    check_eq("edge_gap", 32'(ps_gap), 32'd64);

    // Mid-period load of 15
    steps(20);
    load_once(8'h0F, 1'b0);
    check_eq("mid_pending", 32'(pending), 32'd1);
    wait_ps(200, n);
    check_eq("mid_commit_pend", 32'(pending), 32'd0);
    step();
    run_window(64, hi0, hi1, nps);
    check_eq("edge15_hi0", 32'(hi0), 32'd60);

    // Center mode, ch0=5
    steps(7);
    load_once(8'h05, 1'b1);
    wait_ps(200, n);
    step();
    run_window(120, hi0, hi1, nps);
    check_eq("center5_hi0", 32'(hi0), 32'(center_hi));
    check_eq("center5_nps", 32'(nps), 32'd1);
    check_eq("center_gap", 32'(ps_gap), 32'd120);

    // Load on the boundary tick, back to edge with ch0=3
    wait_model_bnd(300);
    pend_seen = 0;
    load_once(8'h03, 1'b0);
    check_eq("bnd_ps", 32'(period_start), 32'd1);
    check_eq("bnd_pending", 32'(pending), 32'd0);
    step();
    check_eq("bnd_first_out", 32'(pwm_out[0]), 32'd1);
    run_window(64, hi0, hi1, nps);
    check_eq("bnd3_hi0", 32'(hi0), 32'd12);
    check_eq("bnd_pend_never", 32'(pend_seen), 32'd0);

    // Two loads in one period: last wins
    steps(10);
    load_once(8'h03, 1'b0);
    steps(10);
    load_once(8'h07, 1'b0);
    wait_ps(200, n);
    step();
    run_window(64, hi0, hi1, nps);
    check_eq("last_load_hi0", 32'(hi0), 32'd28);

    // Enable drop and restore mid-high
    wait_ps(200, n);
    steps(5);
    en = 2'b10;
    step();
    check_eq("en_off_low", 32'(pwm_out[0]), 32'd0);
    steps(3);
    en = 2'b11;
    step();
    check_eq("en_on_high", 32'(pwm_out[0]), 32'd1);
    wait_ps(200, n);
    check_eq("en_gap", 32'(ps_gap), 32'd64);

    // Reset with a load pending
    steps(10);
    load_once(8'h09, 1'b0);
    steps(5);
    rst = 1'b1;
    step();
    check_eq("rst2_pwm", 32'(pwm_out), 32'd0);
    check_eq("rst2_ps", 32'(period_start), 32'd0);
    check_eq("rst2_pending", 32'(pending), 32'd0);
    rst = 1'b0;
    wait_ps(200, n);
    check_eq("rst2_first_bnd", 32'(n), 32'd64);
    run_window(64, hi0, hi1, nps);
    check_eq("rst2_duty_zero", 32'(hi0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
